// File: rtl/delta_pkg.sv
// ---------------------------------------------------------------------------
// delta_pkg : shared constants and types for the delta_decoder block
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package delta_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_ALIGN = 2;

  typedef logic [DEFAULT_WIDTH-1:0] delta_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

`default_nettype wire

// File: rtl/delta_decoder_if.sv
// ---------------------------------------------------------------------------
// delta_decoder_if : total input plus delta output stream of delta_decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface delta_decoder_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             err;
  logic [7:0]       out_cnt;

  modport master (
    input  din,
    input  out_ready,
    output out_valid,
    output out_data,
    output err,
    output out_cnt
  );

  modport slave (
    output din,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  err,
    input  out_cnt
  );

endinterface

`default_nettype wire

// File: rtl/delta_skid.sv
// ---------------------------------------------------------------------------
// delta_skid : 2-entry delta buffer; a push into a full buffer merges into
//              the tail so the sum of all deltas is preserved.
// Build option: DELTA_DECODER_FORMAL_EN exposes the buffered-sum port.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module delta_skid
  import delta_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_push_data,
  input  wire logic             i_pop,
  output occ_t                  o_occ,
`ifdef DELTA_DECODER_FORMAL_EN
  output logic      [WIDTH-1:0] o_buf_sum,
`endif
  output logic      [WIDTH-1:0] o_head
);

  occ_t             r_occ;
  occ_t             w_occ_nxt;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [WIDTH-1:0] w_head_nxt;
  logic [WIDTH-1:0] w_tail_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ  <= EMPTY;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_occ  <= w_occ_nxt;
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
    end
  end

  always_comb begin
    w_occ_nxt  = r_occ;
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    case (r_occ)
      EMPTY: begin
        if (i_push) begin
          w_occ_nxt  = ONE;
          w_head_nxt = i_push_data;
        end
      end
      ONE: begin
        case ({i_push, i_pop})
          2'b10: begin
            w_occ_nxt  = FULL;
            w_tail_nxt = i_push_data;
          end
          2'b01: w_occ_nxt = EMPTY;
          2'b11: w_head_nxt = i_push_data;
          default: ;
        endcase
      end
      FULL: begin
        case ({i_push, i_pop})
          2'b01: begin
            w_occ_nxt  = ONE;
            w_head_nxt = r_tail;
          end
          2'b11: begin
            w_head_nxt = r_tail;
            w_tail_nxt = i_push_data;
          end
          // Stalled while full: fold the new delta into the tail.
          2'b10: w_tail_nxt = r_tail + i_push_data;
          default: ;
        endcase
      end
      default: w_occ_nxt = EMPTY;
    endcase
  end

  assign o_occ  = r_occ;
  assign o_head = (r_occ == EMPTY) ? '0 : r_head;

`ifdef DELTA_DECODER_FORMAL_EN
  assign o_buf_sum = (r_occ == EMPTY) ? '0 :
                     (r_occ == ONE)   ? r_head : (r_head + r_tail);
`endif

endmodule

`default_nettype wire

// File: rtl/delta_decoder.sv
// ---------------------------------------------------------------------------
// delta_decoder : recovers increments from an accumulator's running total,
//                 flags misaligned changes and streams deltas out.
// Build option: DELTA_DECODER_FORMAL_EN compiles in immediate assertions.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module delta_decoder
  import delta_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ALIGN = DEFAULT_ALIGN
) (
  input wire logic        clk,
  input wire logic        reset,
  delta_decoder_if.master bus
);

  logic [WIDTH-1:0] r_prev;
  logic             r_err;
  logic [7:0]       r_cnt;

  logic             w_change;
  logic [WIDTH-1:0] w_delta;
  logic             w_aligned;
  logic             w_push;
  logic             w_valid;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  occ_t             w_occ;

  assign w_change  = (bus.din != r_prev);
  assign w_delta   = bus.din - r_prev;
  assign w_aligned = (w_delta[ALIGN-1:0] == '0);
  assign w_push    = w_change && w_aligned;
  assign w_valid   = (w_occ != EMPTY);
  assign w_pop     = w_valid && bus.out_ready;

`ifdef DELTA_DECODER_FORMAL_EN
  logic [WIDTH-1:0] w_buf_sum;
`endif

  delta_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_delta),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
`ifdef DELTA_DECODER_FORMAL_EN
    .o_buf_sum   (w_buf_sum),
`endif
    .o_head      (w_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= bus.din;
      if (w_change && !w_aligned) begin
        r_err <= 1'b1;
      end
      if (w_pop && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_head;
  assign bus.err       = r_err;
  assign bus.out_cnt   = r_cnt;

`ifdef DELTA_DECODER_FORMAL_EN
  logic [WIDTH-1:0] r_emit_sum;
  logic [WIDTH-1:0] r_last_head;
  logic             r_stalled;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_emit_sum  <= '0;
      r_last_head <= '0;
      r_stalled   <= 1'b0;
    end else begin
      a_align:  assert (!(w_valid && !r_err) || (w_head[ALIGN-1:0] == '0));
      a_occ:    assert (w_occ inside {EMPTY, ONE, FULL});
      a_stable: assert (!r_stalled || (w_head == r_last_head));
      // Misaligned deltas are dropped, so conservation only holds without err.
      a_sum:    assert (r_err || ((w_buf_sum + r_emit_sum) == r_prev));
      if (w_pop) begin
        r_emit_sum <= r_emit_sum + w_head;
      end
      r_last_head <= w_head;
      r_stalled   <= w_valid && !bus.out_ready;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_delta_decoder.sv
// ---------------------------------------------------------------------------
// tb_delta_decoder : directed vector table plus randomized run against a
//                    queue-based reference model of delta_decoder.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_delta_decoder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  delta_decoder_if #(.WIDTH(8)) bus ();

  delta_decoder #(
    .WIDTH (8),
    .ALIGN (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic       rst;
    logic [7:0] din;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       ee;
    logic [7:0] ec;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [7:0] din, logic rdy,
                              logic ev, logic [7:0] ed, logic ee, logic [7:0] ec);
    vec_t v;
    v.rst = rst; v.din = din; v.rdy = rdy;
    v.ev  = ev;  v.ed  = ed;  v.ee  = ee;  v.ec = ec;
    return v;
  endfunction

  task automatic check(string name, logic ev, logic [7:0] ed, logic ee, logic [7:0] ec);
    checks++;
    if (bus.out_valid !== ev || bus.out_data !== ed || bus.err !== ee || bus.out_cnt !== ec) begin
      failures++;
      $display("FAIL %s: got valid=%0b data=%02h err=%0b cnt=%0d, want valid=%0b data=%02h err=%0b cnt=%0d",
               name, bus.out_valid, bus.out_data, bus.err, bus.out_cnt, ev, ed, ee, ec);
    end
  endtask

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] m_prev;
  logic       m_err;
  logic [7:0] m_cnt;

  task automatic model_step(logic rst, logic [7:0] din, logic rdy);
    logic [7:0] d;
    if (rst) begin
      m_q.delete();
      m_prev = 8'h00;
      m_err  = 1'b0;
      m_cnt  = 8'h00;
    end else begin
      if (m_q.size() > 0 && rdy) begin
        void'(m_q.pop_front());
        if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
      end
      if (din != m_prev) begin
        d = din - m_prev;
        if (d % 4 != 0) m_err = 1'b1;
        else if (m_q.size() < 2) m_q.push_back(d);
        else m_q[1] = m_q[1] + d;
      end
      m_prev = din;
    end
  endtask

  initial begin
    logic [7:0] din_r;
    logic       rst_r;
    logic       rdy_r;
    int         k;
    bit         saw_sat;

    reset         = 1'b1;
    bus.din       = 8'h00;
    bus.out_ready = 1'b0;

    //            rst   din    rdy   valid data  err  cnt
    tbl.push_back(mk(1, 8'h00, 1,    0, 8'h00, 0, 8'd0)); // basic
    tbl.push_back(mk(0, 8'h04, 1,    1, 8'h04, 0, 8'd0));
    tbl.push_back(mk(0, 8'h04, 1,    0, 8'h00, 0, 8'd1));
    tbl.push_back(mk(1, 8'h00, 0,    0, 8'h00, 0, 8'd0)); // stall + merge
    tbl.push_back(mk(0, 8'h04, 0,    1, 8'h04, 0, 8'd0));
    tbl.push_back(mk(0, 8'h0C, 0,    1, 8'h04, 0, 8'd0));
    tbl.push_back(mk(0, 8'h14, 0,    1, 8'h04, 0, 8'd0));
    tbl.push_back(mk(0, 8'h14, 1,    1, 8'h10, 0, 8'd1));
    tbl.push_back(mk(0, 8'h14, 1,    0, 8'h00, 0, 8'd2));
    tbl.push_back(mk(1, 8'h00, 1,    0, 8'h00, 0, 8'd0)); // wrap-around
    tbl.push_back(mk(0, 8'hF8, 1,    1, 8'hF8, 0, 8'd0));
    tbl.push_back(mk(0, 8'h04, 1,    1, 8'h0C, 0, 8'd1));
    tbl.push_back(mk(0, 8'h04, 1,    0, 8'h00, 0, 8'd2));
    tbl.push_back(mk(1, 8'h00, 1,    0, 8'h00, 0, 8'd0)); // misaligned
    tbl.push_back(mk(0, 8'h05, 1,    0, 8'h00, 1, 8'd0));
    tbl.push_back(mk(0, 8'h09, 1,    1, 8'h04, 1, 8'd0));
    tbl.push_back(mk(0, 8'h09, 1,    0, 8'h00, 1, 8'd1));
    tbl.push_back(mk(1, 8'h00, 0,    0, 8'h00, 0, 8'd0)); // full + push + pop
    tbl.push_back(mk(0, 8'h04, 0,    1, 8'h04, 0, 8'd0));
    tbl.push_back(mk(0, 8'h08, 0,    1, 8'h04, 0, 8'd0));
    tbl.push_back(mk(0, 8'h10, 1,    1, 8'h04, 0, 8'd1));
    tbl.push_back(mk(0, 8'h10, 1,    1, 8'h08, 0, 8'd2));
    tbl.push_back(mk(0, 8'h10, 1,    0, 8'h00, 0, 8'd3));
    tbl.push_back(mk(1, 8'h00, 0,    0, 8'h00, 0, 8'd0)); // reset while full
    tbl.push_back(mk(0, 8'h04, 0,    1, 8'h04, 0, 8'd0));
    tbl.push_back(mk(0, 8'h08, 0,    1, 8'h04, 0, 8'd0));
    tbl.push_back(mk(1, 8'h08, 1,    0, 8'h00, 0, 8'd0));
    tbl.push_back(mk(0, 8'h04, 1,    1, 8'h04, 0, 8'd0));
    tbl.push_back(mk(0, 8'h04, 1,    0, 8'h00, 0, 8'd1));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      reset         = tbl[i].rst;
      bus.din       = tbl[i].din;
      bus.out_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ee, tbl[i].ec);
    end

    // Randomized run against the reference model
    reset = 1'b1; bus.din = 8'h00; bus.out_ready = 1'b0;
    model_step(1'b1, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("rnd_reset", 1'b0, 8'h00, 1'b0, 8'd0);
    din_r   = 8'h00;
    saw_sat = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      k = $urandom_range(0, 999);
      rst_r = (k < 2);
      k = $urandom_range(0, 99);
      if (k >= 30 && k < 98) din_r = din_r + 8'(4 * $urandom_range(1, 63));
      else if (k >= 98)      din_r = din_r + 8'($urandom_range(1, 3));
      rdy_r = ($urandom_range(0, 9) < 8);
      reset         = rst_r;
      bus.din       = din_r;
      bus.out_ready = rdy_r;
      model_step(rst_r, din_r, rdy_r);
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d", c), (m_q.size() > 0), (m_q.size() > 0) ? m_q[0] : 8'h00, m_err, m_cnt);
      if (m_cnt == 8'd255) saw_sat = 1'b1;
    end

    // Force a long reset-free stretch so the pop counter saturates
    if (!saw_sat) begin
      for (int c = 0; c < 600; c++) begin
        din_r = din_r + 8'd4;
        reset = 1'b0; bus.din = din_r; bus.out_ready = 1'b1;
        model_step(1'b0, din_r, 1'b1);
        @(posedge clk);
        #1;
        check($sformatf("sat%0d", c), (m_q.size() > 0), (m_q.size() > 0) ? m_q[0] : 8'h00, m_err, m_cnt);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/delta_decoder.md
# delta_decoder

Reader at the far end of the accumulator's output. Watches the 8-bit running total (`dout` of the accumulator) and reconstructs the individual increments that produced it. Emits each increment on a valid/ready stream through a 2-entry buffer and flags any total change that violates the accumulator's alignment guarantee. Sits downstream of the accumulator as its protocol decoder, in the same formal testbench.

## Interface

Parameters:
- `WIDTH`, 8: total and delta width.
- `ALIGN`, 2: number of low bits every legal delta has at zero.

Ports:
- `clk`, in, 1: clock. One clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `din`, in, WIDTH: running total from the accumulator.
- `out_valid`, out, 1: head delta available.
- `out_ready`, in, 1: consumer accepts the head delta.
- `out_data`, out, WIDTH: head delta.
- `err`, out, 1: sticky alignment violation.
- `out_cnt`, out, 8: number of completed output handshakes, saturating.

## Operation

- `prev` register holds the last total seen; reset value 0, matching the accumulator's reset total.
- Change detect, evaluated every non-reset cycle:
  - Condition: `din != prev`.
  - `delta = din - prev`, mod 2^WIDTH. Wrap-around is legal, e.g. 0xFC to 0x04 gives delta 0x08.
  - `prev <= din`.
- Alignment check: if `delta[ALIGN-1:0] != 0`:
  - `err <= 1` (sticky until reset).
  - The delta is discarded; `prev` still updates.
- Buffer: 2 entries. Occupancy states are EMPTY, ONE and FULL.
  - Pop: `out_valid && out_ready`.
  - Push: an aligned delta.
- Occupancy transitions:
  - EMPTY + push → ONE.
  - ONE + push, no pop → FULL.
  - ONE + pop, no push → EMPTY.
  - ONE + push + pop → ONE (new delta becomes the head).
  - FULL + pop, no push → ONE.
  - FULL + push + pop → FULL (head retires, new delta goes to the tail).
  - FULL + push, no pop → FULL, with merge: tail ← tail + delta, mod 2^WIDTH. The sum of emitted deltas always equals the total change; no data is lost.
- Output stream:
  - `out_valid = (occupancy != EMPTY)`.
  - `out_data` = head entry, or 0 when empty.
  - Head holds stable while `out_valid && !out_ready`.
- `out_cnt` increments on each pop and saturates at 255.

## Timing

- Latency: a `din` change sampled at edge N gives `out_valid = 1` with that delta after edge N, i.e. one cycle. There is no combinational path from `din` to the outputs.
- `out_ready` affects state only at the edge. `out_valid` never depends combinationally on `out_ready`.
- Reset values, applied in the cycle after `reset` is sampled high:
  - `prev = 0`, occupancy EMPTY.
  - `out_valid = 0`, `out_data = 0`, `err = 0`, `out_cnt = 0`.
- Reset mid-operation drops all buffered deltas. The pop in the reset cycle is not counted.
- A `din` change during the reset cycle is ignored, and `prev` is forced to 0.

## Configuration

- `DELTA_DECODER_FORMAL_EN` defined: immediate assertions are compiled in.
  - `out_valid && !err` implies `out_data[ALIGN-1:0] == 0`.
  - Occupancy never exceeds 2.
  - `$stable(out_data)` across a stalled cycle.
  - Sum of buffered entries plus emitted deltas equals `prev` mod 2^WIDTH.
- Undefined: no assertions; RTL is otherwise identical.

## Structure

- Package `delta_pkg`:
  - `WIDTH` and `ALIGN` default constants.
  - Occupancy enum `occ_t` {EMPTY, ONE, FULL}.
  - Width typedef `delta_t`.
- Sub-module `delta_skid`: the 2-entry buffer with merge-on-full, push/pop ports and occupancy output. The top module holds change detect, alignment check, `err` and `out_cnt`.

## Test plan

- Reset, then `din` 0 → 4, `out_ready = 1`: one cycle later `out_valid = 1`, `out_data = 4`; next cycle `out_valid = 0`; `out_cnt = 1`.
- `out_ready = 0`, `din` 0 → 4 → 12 → 20 (one change per cycle):
  - Entries 4 and 8, then tail merges to 16.
  - Releasing ready yields 4, then 16; `out_cnt = 2`.
- `din` 0xF8 → 0x04 with `prev = 0xF8`: `out_data = 0x0C` (wrap-around), `err = 0`.
- `din` 0 → 5: `err = 1`, no `out_valid`. A later `din` 5 → 9 is emitted as 4 with `err` still 1.
- FULL with `out_ready = 1` and a simultaneous new delta 8: head retires and tail gets 8 unmerged; occupancy stays FULL.
- Reset asserted while FULL: next cycle `out_valid = 0` and `out_cnt = 0`; `din` 0 → 4 then gives `out_data = 4`.
